// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding,
// wait-state counter width and the word-index width helper.
package dmem_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int CNT_W = 4;

   function automatic int idx_width(input int depth_words);
      return $clog2(depth_words);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-writable single-port word RAM with a registered read port.
// No reset: contents survive controller resets.
module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic [3:0]       we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wd,
   output logic [31:0]      rd
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
         end
         rd <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store port controller: accepts one access, waits WAIT_STATES cycles,
// commits it to dmem_array on the edge into RESP and pulses valid.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        request,
   input  logic        load,
   input  logic        store,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  mask,
   output logic        valid,
   output logic [31:0] dataMem_out,
   output logic        busy,
   output logic        oob
);

   localparam int IDX_W = idx_width(DEPTH_WORDS);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [29:0]      idx_q, a_idx;
   logic [31:0]      wdata_q, dout_q, rd, a_wd;
   logic [3:0]       mask_q, a_mask;
   logic             ld_q, st_q, a_ld, a_st, a_inr, inr_q;
   logic             accept, from_in, enter_resp;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^addr[1:0];
   assign accept = (state == ST_IDLE) && request;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (request) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
         ST_WAIT: if (cnt == CNT_W'(1)) state_nxt = ST_RESP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // With zero wait states RESP is entered straight from IDLE, so the array
   // must see the live inputs rather than the (not yet) latched copies.
   assign from_in    = (state == ST_IDLE);
   assign a_idx      = from_in ? addr[31:2] : idx_q;
   assign a_wd       = from_in ? wdata : wdata_q;
   assign a_mask     = from_in ? mask : mask_q;
   assign a_st       = from_in ? store : st_q;
   assign a_ld       = from_in ? (load & ~store) : ld_q;
   assign a_inr      = (a_idx >> IDX_W) == 30'd0;
   assign inr_q      = (idx_q >> IDX_W) == 30'd0;
   assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);

   dmem_array #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk (clk),
      .en  (enter_resp && a_inr && (a_ld || a_st)),
      .we  (a_st ? a_mask : 4'b0000),
      .idx (a_idx[IDX_W-1:0]),
      .wd  (a_wd),
      .rd  (rd)
   );

   assign valid       = (state == ST_RESP);
   assign busy        = (state != ST_IDLE);
   assign dataMem_out = (valid && ld_q) ? (inr_q ? rd : 32'd0) : dout_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         dout_q  <= '0;
         oob     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            idx_q   <= addr[31:2];
            wdata_q <= wdata;
            mask_q  <= mask;
            st_q    <= store;
            ld_q    <= load & ~store;
            cnt     <= CNT_W'(WAIT_STATES);
            if ((addr[31:2] >> IDX_W) != 30'd0) oob <= 1'b1;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (valid) dout_q <= dataMem_out;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances with WAIT_STATES 0, 3 and 4.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  req, ld, st, vld, bsy, oob;
   logic [31:0] ad [3];
   logic [31:0] wd [3];
   logic [3:0]  mk [3];
   logic [31:0] dout [3];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
      .clk(clk), .rst(rst), .request(req[0]), .load(ld[0]), .store(st[0]),
      .addr(ad[0]), .wdata(wd[0]), .mask(mk[0]),
      .valid(vld[0]), .dataMem_out(dout[0]), .busy(bsy[0]), .oob(oob[0]));

   dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
      .clk(clk), .rst(rst), .request(req[1]), .load(ld[1]), .store(st[1]),
      .addr(ad[1]), .wdata(wd[1]), .mask(mk[1]),
      .valid(vld[1]), .dataMem_out(dout[1]), .busy(bsy[1]), .oob(oob[1]));

   dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(4)) u4 (
      .clk(clk), .rst(rst), .request(req[2]), .load(ld[2]), .store(st[2]),
      .addr(ad[2]), .wdata(wd[2]), .mask(mk[2]),
      .valid(vld[2]), .dataMem_out(dout[2]), .busy(bsy[2]), .oob(oob[2]));

   task automatic drive(input int i, input bit r, input bit l, input bit s,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      req[i] = r; ld[i] = l; st[i] = s; ad[i] = a; wd[i] = d; mk[i] = m;
   endtask

   // One access; returns cycles from request to valid and data seen with valid.
   task automatic acc(input int i, input bit l, input bit s, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      output int lat, output logic [31:0] q);
      lat = -1;
      q = 32'h0;
      @(negedge clk);
      drive(i, 1'b1, l, s, a, d, m);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) drive(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         if (vld[i] && lat < 0) begin
            lat = k;
            q = dout[i];
         end
         if (lat >= 0) break;
      end
      @(negedge clk);
      checks++;
      if (lat < 0) begin
         errors++;
         $display("FAIL acc_timeout inst=%0d addr=%h: no valid within 20 cycles", i, a);
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({vld[i], bsy[i], oob[i]} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags inst=%0d: got v/b/o=%b expected 000", i, {vld[i], bsy[i], oob[i]});
         end
         checks++;
         if (dout[i] !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout inst=%0d: got %h expected 00000000", i, dout[i]);
         end
      end
   endtask

   task automatic test_w0_store_load;
      int lat;
      logic [31:0] q;
      acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, q);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL w0_store_latency: got %0d expected 1", lat);
      end
      checks++;
      if (q !== 32'h0) begin
         errors++;
         $display("FAIL w0_store_dout_held: got %h expected 00000000", q);
      end
      acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, q);
      checks++;
      if (lat !== 1 || q !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL w0_load: got lat=%0d data=%h expected lat=1 data=deadbeef", lat, q);
      end
      checks++;
      if (dout[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL w0_dout_hold: got %h expected deadbeef", dout[0]);
      end
   endtask

   task automatic test_byte_lanes;
      int lat;
      logic [31:0] q;
      acc(0, 1'b0, 1'b1, 32'h14, 32'h11223344, 4'hF, lat, q);
      acc(0, 1'b0, 1'b1, 32'h14, 32'h000000AA, 4'b0001, lat, q);
      acc(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, q);
      checks++;
      if (q !== 32'h112233AA) begin
         errors++;
         $display("FAIL byte_lane0: got %h expected 112233aa", q);
      end
      acc(0, 1'b0, 1'b1, 32'h17, 32'h55660000, 4'b1100, lat, q);
      acc(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, q);
      checks++;
      if (q !== 32'h556633AA) begin
         errors++;
         $display("FAIL byte_half_hi: got %h expected 556633aa", q);
      end
      acc(0, 1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, lat, q);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL mask0_valid: got lat=%0d expected 1", lat);
      end
      acc(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, q);
      checks++;
      if (q !== 32'h556633AA) begin
         errors++;
         $display("FAIL mask0_nowrite: got %h expected 556633aa", q);
      end
   endtask

   task automatic test_w3_timing;
      bit exp_b, exp_v, seen;
      int lat;
      logic [31:0] q;
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         exp_b = (k != 5);
         exp_v = (k == 4);
         checks++;
         if (bsy[1] !== exp_b) begin
            errors++;
            $display("FAIL w3_busy k=%0d: got %b expected %b", k, bsy[1], exp_b);
         end
         checks++;
         if (vld[1] !== exp_v) begin
            errors++;
            $display("FAIL w3_valid k=%0d: got %b expected %b", k, vld[1], exp_v);
         end
      end
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      seen = 1'b0;
      for (int k = 7; k <= 30 && !seen; k++) begin
         @(negedge clk);
         if (vld[1]) begin
            seen = 1'b1;
            checks++;
            if (k != 9) begin
               errors++;
               $display("FAIL w3_second_valid: got k=%0d expected 9", k);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL w3_second_timeout: no valid seen");
      end
      acc(1, 1'b0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, lat, q);
      acc(1, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, lat, q);
      checks++;
      if (lat !== 4 || q !== 32'h0BADF00D || oob[1] !== 1'b0) begin
         errors++;
         $display("FAIL w3_top_word: got lat=%0d data=%h oob=%b expected 4 0badf00d 0", lat, q, oob[1]);
      end
   endtask

   task automatic test_oob;
      int lat;
      logic [31:0] q;
      acc(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, q);
      checks++;
      if (lat !== 1 || q !== 32'h0 || oob[0] !== 1'b1) begin
         errors++;
         $display("FAIL oob_load: got lat=%0d data=%h oob=%b expected 1 00000000 1", lat, q, oob[0]);
      end
      // 0x1010 aliases word 4 (0x10) if the high index bits were dropped.
      acc(0, 1'b0, 1'b1, 32'h1010, 32'h99999999, 4'hF, lat, q);
      acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, q);
      checks++;
      if (q !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL oob_store_dropped: got %h expected deadbeef", q);
      end
      checks++;
      if (oob[0] !== 1'b1) begin
         errors++;
         $display("FAIL oob_sticky: got %b expected 1", oob[0]);
      end
   endtask

   task automatic test_both;
      int lat, pulses;
      logic [31:0] q;
      acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, q);
      pulses = 0;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b1, 32'h18, 32'h12345678, 4'hF);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         if (vld[0]) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL both_pulses: got %0d expected 1", pulses);
      end
      checks++;
      if (dout[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL both_dout_held: got %h expected deadbeef", dout[0]);
      end
      acc(0, 1'b1, 1'b0, 32'h18, 32'h0, 4'h0, lat, q);
      checks++;
      if (q !== 32'h12345678) begin
         errors++;
         $display("FAIL both_written: got %h expected 12345678", q);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      bit seen;
      logic [31:0] q;
      acc(2, 1'b0, 1'b1, 32'h20, 32'h11112222, 4'hF, lat, q);
      @(negedge clk);
      drive(2, 1'b1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (vld[2] || bsy[2]) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rst_mid_quiet: got valid/busy activity expected none");
      end
      checks++;
      if (oob[0] !== 1'b0 || dout[0] !== 32'h0) begin
         errors++;
         $display("FAIL rst_clears: got oob=%b dout=%h expected 0 00000000", oob[0], dout[0]);
      end
      acc(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, q);
      checks++;
      if (lat !== 5 || q !== 32'h11112222) begin
         errors++;
         $display("FAIL rst_mid_discard: got lat=%0d data=%h expected 5 11112222", lat, q);
      end
   endtask

   initial begin
      test_reset;
      test_w0_store_load;
      test_byte_lanes;
      test_w3_timing;
      test_oob;
      test_both;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
